hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
//
// PURPOSE
//   Pipeline sequencer for the fetch/decode/execute/memory stages.
//   - Detects load-use hazards against the instruction in decode.
//   - Holds the pipe while data memory is busy.
//   - Flushes the younger stages after a taken branch.
//   Drives the sel_stall input of execute_unit; it does not drive the forwarding muxes.
//
// PARAMETERS
//   FLUSH_CYCLES  2   cycles flush_* stay high after a taken branch (1..7)
//   MEM_TIMEOUT   15  max consecutive mem_busy cycles before mem_err (1..255)
//
// PORTS
//   clk            in   1  rising-edge clock
//   reset          in   1  synchronous, active-low reset
//   dec_rn         in   4  Rn of the instruction in decode
//   dec_rm         in   4  Rm of the instruction in decode
//   dec_rs         in   4  Rs of the instruction in decode
//   dec_use        in   3  {rs,rm,rn} valid bits for the decode operands
//   ex_rd          in   4  destination register of the instruction in execute
//   ex_is_load     in   1  execute holds LDR/LDR_Lit
//   ex_wb_en       in   1  execute instruction writes ex_rd
//   branch_taken   in   1  branch resolved taken this cycle (one-cycle pulse)
//   mem_busy       in   1  data memory not ready
//   stall_fetch    out  1  hold PC / fetch register
//   stall_decode   out  1  hold decode register
//   sel_stall      out  1  insert bubble into execute (to execute_unit)
//   stall_execute  out  1  hold the execute/memory registers
//   flush_fetch    out  1  invalidate fetch register
//   flush_decode   out  1  invalidate decode register
//   mem_err        out  1  sticky memory timeout flag
//   state          out  2  current FSM state (debug)
//
// BEHAVIOUR
//   States: RUN=0, MEM_WAIT=1, FLUSH=2, ERR=3.
//   - Reset (reset==0 at posedge): state=RUN, counters=0, pend_br=0, mem_err=0.
//   - Every output is 0 while reset is low and on the first cycle after reset.
//   - Load-use hazard (combinational): ex_is_load & ex_wb_en & ex_rd!=4'hF
//     & any enabled dec_* equal to ex_rd.
//   RUN:
//   - Priority: branch_taken > mem_busy > load-use.
//   - branch_taken -> FLUSH, flush count = FLUSH_CYCLES.
//   - mem_busy -> stall_fetch=stall_decode=stall_execute=1 in the same cycle; next state MEM_WAIT, wait count = 1.
//   - Load-use -> stall_fetch=stall_decode=sel_stall=1 in the same cycle (one-cycle bubble); state stays RUN.
//   MEM_WAIT:
//   - All three stall outputs stay 1 while mem_busy is 1.
//   - A branch_taken pulse arriving here sets pend_br.
//   - mem_busy falls -> stalls drop that cycle. Next state is FLUSH if pend_br, else RUN.
//   - Wait count reaches MEM_TIMEOUT with mem_busy still 1 -> ERR, mem_err=1.
//   FLUSH:
//   - flush_fetch=flush_decode=1 for exactly FLUSH_CYCLES cycles, then RUN.
//   - Load-use detection is masked during FLUSH.
//   - branch_taken during FLUSH reloads the count to FLUSH_CYCLES.
//   - mem_busy during FLUSH asserts stall_execute only; the flush count still decrements.
//   ERR:
//   - stall_fetch=stall_decode=stall_execute=1 and mem_err=1 until reset.
//   Counters:
//   - Flush count is 3 bits, wait count is 8 bits.
//   - Both saturate and never wrap.
//   - pend_br clears on entry to FLUSH.
//   Reset asserted mid-stall or mid-flush aborts it immediately; there is no pending state.
//
// CONFIGURATION
//   HAZARD_PERF_CNT_EN
//   - Defined: adds outputs perf_stalls[31:0], perf_flushes[31:0], perf_memwait[31:0].
//     - perf_stalls counts load-use bubble cycles.
//     - perf_flushes counts FLUSH entries.
//     - perf_memwait counts MEM_WAIT cycles.
//     - All three clear on reset and wrap modulo 2^32.
//   - Undefined: these ports and counters are absent; all other behaviour is identical.
//
// TESTING
//   1. ex_is_load=1, ex_wb_en=1, ex_rd=3, dec_rn=3, dec_use=001
//      -> sel_stall=stall_fetch=stall_decode=1 for exactly 1 cycle; state stays 0.
//   2. Same as 1 with ex_rd=15, or dec_use=000
//      -> no stall.
//   3. branch_taken pulse in RUN
//      -> flush_fetch=flush_decode=1 for 2 cycles, state 2 then 0.
//   4. mem_busy high 4 cycles with a branch_taken pulse in cycle 2
//      -> stalls high 4 cycles, then flush for 2 cycles.
//   5. mem_busy held 20 cycles
//      -> state 3 and mem_err=1 after 15 cycles; cleared only by reset=0.
//   6. reset=0 during FLUSH
//      -> next cycle all outputs 0, state 0; with HAZARD_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencer for fetch/decode/execute/memory.
// Detects load-use hazards, holds the pipe on data-memory busy, flushes the
// younger stages after a taken branch, and raises a sticky memory timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit performance counters.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,   // 1..7
    parameter int unsigned MEM_TIMEOUT  = 15   // 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dec_rn,
    input  logic [3:0]  dec_rm,
    input  logic [3:0]  dec_rs,
    input  logic [2:0]  dec_use,
    input  logic [3:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_wb_en,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        sel_stall,
    output logic        stall_execute,
    output logic        flush_fetch,
    output logic        flush_decode,
    output logic        mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_memwait,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2,
        StErr     = 2'd3
    } state_e;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);
    localparam logic [7:0] WaitMax   = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_inc;
    logic       pend_br_q, pend_br_d;
    logic       mem_err_q, mem_err_d;
    // Low on the first cycle after reset so that cycle is fully quiet.
    logic       active_q;

    logic       load_use;
    logic       sf_raw, sd_raw, sel_raw, se_raw, flush_raw;

    // Load-use hazard: a load in execute writing a register that decode reads.
    always_comb begin
        load_use = ex_is_load && ex_wb_en && (ex_rd != 4'hF) &&
                   ((dec_use[0] && (dec_rn == ex_rd)) ||
                    (dec_use[1] && (dec_rm == ex_rd)) ||
                    (dec_use[2] && (dec_rs == ex_rd)));
    end

    // Next-state, counter and same-cycle output decode.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        pend_br_d   = pend_br_q;
        mem_err_d   = mem_err_q;
        sf_raw      = 1'b0;
        sd_raw      = 1'b0;
        sel_raw     = 1'b0;
        se_raw      = 1'b0;
        flush_raw   = 1'b0;
        wait_inc    = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                    pend_br_d   = 1'b0;
                end else if (mem_busy) begin
                    sf_raw     = 1'b1;
                    sd_raw     = 1'b1;
                    se_raw     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else if (load_use) begin
                    sf_raw  = 1'b1;
                    sd_raw  = 1'b1;
                    sel_raw = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_busy) begin
                    sf_raw     = 1'b1;
                    sd_raw     = 1'b1;
                    se_raw     = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (branch_taken) begin
                        pend_br_d = 1'b1;
                    end
                    if (wait_inc >= WaitMax) begin
                        state_d   = StErr;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = 8'd0;
                    if (pend_br_q || branch_taken) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushLoad;
                        pend_br_d   = 1'b0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFlush: begin
                flush_raw = 1'b1;
                se_raw    = mem_busy;
                if (branch_taken) begin
                    flush_cnt_d = FlushLoad;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            StErr: begin
                sf_raw    = 1'b1;
                sd_raw    = 1'b1;
                se_raw    = 1'b1;
                mem_err_d = 1'b1;
            end
            default: state_d = StRun;
        endcase

        // Ignore all inputs on the first cycle after reset.
        if (!active_q) begin
            state_d     = StRun;
            flush_cnt_d = 3'd0;
            wait_cnt_d  = 8'd0;
            pend_br_d   = 1'b0;
            mem_err_d   = 1'b0;
            sf_raw      = 1'b0;
            sd_raw      = 1'b0;
            sel_raw     = 1'b0;
            se_raw      = 1'b0;
            flush_raw   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StRun;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            pend_br_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_br_q   <= pend_br_d;
            mem_err_q   <= mem_err_d;
            active_q    <= 1'b1;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        stall_fetch   = reset && sf_raw;
        stall_decode  = reset && sd_raw;
        sel_stall     = reset && sel_raw;
        stall_execute = reset && se_raw;
        flush_fetch   = reset && flush_raw;
        flush_decode  = reset && flush_raw;
        mem_err       = reset && mem_err_q;
        state         = reset ? state_q : StRun;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;
    logic [31:0] perf_memwait_q, perf_memwait_d;

    // Event counters; a branch reloading an active flush is not a new entry.
    always_comb begin
        perf_stalls_d  = perf_stalls_q + {31'd0, sel_raw};
        perf_flushes_d = perf_flushes_q +
                         {31'd0, (state_d == StFlush) && (state_q != StFlush)};
        perf_memwait_d = perf_memwait_q + {31'd0, state_q == StMemWait};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
            perf_memwait_q <= 32'd0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    // Counter outputs, low while reset is held.
    always_comb begin
        perf_stalls  = reset ? perf_stalls_q : 32'd0;
        perf_flushes = reset ? perf_flushes_q : 32'd0;
        perf_memwait = reset ? perf_memwait_q : 32'd0;
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
// Output vector layout: {sf, sd, sel, se, ff, fd, mem_err, state[1:0]}.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dec_rn, dec_rm, dec_rs, ex_rd;
    logic [2:0] dec_use;
    logic       ex_is_load, ex_wb_en, branch_taken, mem_busy;
    logic       stall_fetch, stall_decode, sel_stall, stall_execute;
    logic       flush_fetch, flush_decode, mem_err;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stalls, perf_flushes, perf_memwait;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] OIdle   = 9'h000;
    localparam logic [8:0] OBubble = 9'h1C0;
    localparam logic [8:0] OMemRun = 9'h1A0;
    localparam logic [8:0] OMemWt  = 9'h1A1;
    localparam logic [8:0] OWtIdle = 9'h001;
    localparam logic [8:0] OFlush  = 9'h01A;
    localparam logic [8:0] OFlushE = 9'h03A;
    localparam logic [8:0] OErr    = 9'h1A7;

    wire [8:0] obs = {stall_fetch, stall_decode, sel_stall, stall_execute,
                      flush_fetch, flush_decode, mem_err, state};

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk          (clk),
        .reset        (reset),
        .dec_rn       (dec_rn),
        .dec_rm       (dec_rm),
        .dec_rs       (dec_rs),
        .dec_use      (dec_use),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_wb_en     (ex_wb_en),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .stall_fetch  (stall_fetch),
        .stall_decode (stall_decode),
        .sel_stall    (sel_stall),
        .stall_execute(stall_execute),
        .flush_fetch  (flush_fetch),
        .flush_decode (flush_decode),
        .mem_err      (mem_err),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes),
        .perf_memwait (perf_memwait),
`endif
        .state        (state)
    );

    typedef struct packed {
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] rs;
        logic [2:0] use_v;
        logic [3:0] rd;
        logic       ld;
        logic       wb;
        logic       bubble;
    } lu_vec_t;

    task automatic idle_inputs();
        dec_rn = 4'd0; dec_rm = 4'd0; dec_rs = 4'd0; dec_use = 3'b000;
        ex_rd = 4'd0; ex_is_load = 1'b0; ex_wb_en = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        mem_busy = 1'b1; ex_is_load = 1'b1; ex_wb_en = 1'b1;
        ex_rd = 4'd3; dec_rn = 4'd3; dec_use = 3'b001;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL reset_pre_edge obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL reset_held obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
        reset = 1'b1;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL reset_first_cycle obs=%h exp=%h", obs, OIdle);
        end
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if ({perf_stalls, perf_flushes, perf_memwait} !== 96'd0) begin
            failures++;
            $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0",
                     perf_stalls, perf_flushes, perf_memwait);
        end
        checks++;
`endif
        advance();
        idle_inputs();
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL reset_no_transition obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
    endtask

    task automatic test_load_use();
        lu_vec_t v [10];
        v[0] = '{4'd3, 4'd0, 4'd0, 3'b001, 4'd3,  1'b1, 1'b1, 1'b1};
        v[1] = '{4'd15, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b1, 1'b0};
        v[2] = '{4'd3, 4'd0, 4'd0, 3'b000, 4'd3,  1'b1, 1'b1, 1'b0};
        v[3] = '{4'd0, 4'd0, 4'd0, 3'b000, 4'd0,  1'b0, 1'b0, 1'b0};
        v[4] = '{4'd0, 4'd5, 4'd0, 3'b010, 4'd5,  1'b1, 1'b1, 1'b1};
        v[5] = '{4'd0, 4'd0, 4'd9, 3'b100, 4'd9,  1'b1, 1'b1, 1'b1};
        v[6] = '{4'd7, 4'd0, 4'd0, 3'b010, 4'd7,  1'b1, 1'b1, 1'b0};
        v[7] = '{4'd3, 4'd0, 4'd0, 3'b001, 4'd3,  1'b1, 1'b0, 1'b0};
        v[8] = '{4'd3, 4'd0, 4'd0, 3'b001, 4'd3,  1'b0, 1'b1, 1'b0};
        v[9] = '{4'd2, 4'd2, 4'd2, 3'b111, 4'd2,  1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            dec_rn = v[i].rn; dec_rm = v[i].rm; dec_rs = v[i].rs;
            dec_use = v[i].use_v; ex_rd = v[i].rd;
            ex_is_load = v[i].ld; ex_wb_en = v[i].wb;
            @(negedge clk);
            if (obs !== (v[i].bubble ? OBubble : OIdle)) begin
                failures++;
                $display("FAIL load_use_vec%0d obs=%h exp=%h", i, obs,
                         v[i].bubble ? OBubble : OIdle);
            end
            checks++;
            advance();
        end
        idle_inputs();
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL load_use_single_cycle obs=%h exp=%h", obs, OIdle);
        end
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (perf_stalls !== 32'd4) begin
            failures++; $display("FAIL perf_stalls got=%0d exp=4", perf_stalls);
        end
        checks++;
`endif
        advance();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL branch_cycle obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
        // Load-use pattern present but masked during the flush.
        branch_taken = 1'b0;
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd4; dec_rn = 4'd4; dec_use = 3'b001;
        @(negedge clk);
        if (obs !== OFlush) begin
            failures++; $display("FAIL branch_flush1_masked obs=%h exp=%h", obs, OFlush);
        end
        checks++;
        advance();
        idle_inputs();
        mem_busy = 1'b1;
        @(negedge clk);
        if (obs !== OFlushE) begin
            failures++; $display("FAIL branch_flush2_membusy obs=%h exp=%h", obs, OFlushE);
        end
        checks++;
        advance();
        mem_busy = 1'b0;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL branch_back_to_run obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_seq [5];
        exp_seq[0] = OIdle; exp_seq[1] = OFlush; exp_seq[2] = OFlush;
        exp_seq[3] = OFlush; exp_seq[4] = OIdle;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 0) || (i == 1);
            @(negedge clk);
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL back_to_back_c%0d obs=%h exp=%h", i, obs, exp_seq[i]);
            end
            checks++;
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        // busy, branch-in-wait, fall, flush; busy-only; branch+busy priority
        logic [8:0] exp_seq [18];
        logic       busy_seq [18];
        logic       br_seq [18];
        exp_seq = '{OMemRun, OMemWt, OMemWt, OMemWt, OWtIdle, OFlush, OFlush, OIdle,
                    OMemRun, OMemWt, OWtIdle, OIdle,
                    OIdle, OFlushE, OFlushE, OMemRun, OWtIdle, OIdle};
        busy_seq = '{1, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 1, 1, 0, 0};
        br_seq   = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 18; i++) begin
            mem_busy = busy_seq[i];
            branch_taken = br_seq[i];
            @(negedge clk);
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL mem_wait_c%0d obs=%h exp=%h", i, obs, exp_seq[i]);
            end
            checks++;
            advance();
        end
        idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
        if (perf_memwait !== 32'd7 || perf_flushes !== 32'd4) begin
            failures++;
            $display("FAIL perf_mem_flush got=%0d/%0d exp=7/4", perf_memwait, perf_flushes);
        end
        checks++;
`endif
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        for (int k = 1; k <= 20; k++) begin
            mem_busy = 1'b1;
            e = (k == 1) ? OMemRun : (k <= 15) ? OMemWt : OErr;
            @(negedge clk);
            if (obs !== e) begin
                failures++; $display("FAIL timeout_c%0d obs=%h exp=%h", k, obs, e);
            end
            checks++;
            advance();
        end
        mem_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (obs !== OErr) begin
                failures++; $display("FAIL err_sticky_c%0d obs=%h exp=%h", k, obs, OErr);
            end
            checks++;
            advance();
        end
        reset = 1'b0;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL err_reset_low obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
        reset = 1'b1;
        advance();
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL err_cleared obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
    endtask

    task automatic test_reset_in_flush();
        branch_taken = 1'b1;
        advance();
        branch_taken = 1'b0;
        @(negedge clk);
        if (obs !== OFlush) begin
            failures++; $display("FAIL rflush_in_flush obs=%h exp=%h", obs, OFlush);
        end
        checks++;
        advance();
        reset = 1'b0;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL rflush_reset_low obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
        reset = 1'b1;
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL rflush_first_cycle obs=%h exp=%h", obs, OIdle);
        end
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if ({perf_stalls, perf_flushes, perf_memwait} !== 96'd0) begin
            failures++;
            $display("FAIL rflush_perf got=%0d/%0d/%0d exp=0/0/0",
                     perf_stalls, perf_flushes, perf_memwait);
        end
        checks++;
`endif
        advance();
        @(negedge clk);
        if (obs !== OIdle) begin
            failures++; $display("FAIL rflush_not_resumed obs=%h exp=%h", obs, OIdle);
        end
        checks++;
        advance();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
